gan_frame_serializer: RTL and testbench

- Downstream neighbour of gan_serial_top: consumes `generated_frame_flat` / `generated_frame_valid` and streams the frame out one pixel per handshake.
- Each pixel is emitted as a 16-bit signed word plus a thresholded 1-bit value.
- The downstream consumer is a UART/bit-link or a monitor.
- The block decouples the wide parallel generator result from a narrow valid/ready output link.

---
 rtl/gan_pkg.sv | 20 ++
 rtl/gan_frame_serializer_mux.sv | 21 ++
 rtl/gan_frame_serializer.sv | 160 ++++++++++++++++
 tb/tb_gan_frame_serializer.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gan_pkg.sv
// Shared constants and types for the GAN frame output path.
package gan_pkg;

    localparam int FRAME_PIXELS = 784;
    localparam int PIX_W        = 16;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_STREAM = 1'b1
    } state_t;

    // Index width for n entries; never less than one bit.
    function automatic int clog2(input int n);
        int r;
        r = 1;
        while ((1 << r) < n) r++;
        return r;
    endfunction

endpackage

// File: rtl/gan_frame_serializer_mux.sv
// Combinational pixel select: returns pixel[i_idx] from a flat frame vector.
module frame_pixel_mux #(
    parameter int PIXELS = 784,
    parameter int PIX_W  = 16,
    parameter int IDX_W  = 10
) (
    input  logic [PIX_W*PIXELS-1:0] i_flat,
    input  logic [IDX_W-1:0]        i_idx,
    output logic signed [PIX_W-1:0] o_pix
);

    logic [PIX_W-1:0] w_pix [PIXELS];

    for (genvar g = 0; g < PIXELS; g++) begin : g_split
        assign w_pix[g] = i_flat[PIX_W*g +: PIX_W];
    end

    // Indices past the last pixel read as zero instead of undefined.
    assign o_pix = ({1'b0, i_idx} < (IDX_W+1)'(PIXELS)) ? w_pix[i_idx] : '0;

endmodule

// File: rtl/gan_frame_serializer.sv
// Captures a wide generated frame and streams it one pixel per valid/ready
// transfer, with a thresholded bit, first/last markers and done/drop pulses.
module gan_frame_serializer #(
    parameter int                       PIXELS = gan_pkg::FRAME_PIXELS,
    parameter int                       PIX_W  = gan_pkg::PIX_W,
    parameter logic signed [PIX_W-1:0]  THRESH = 16'sd0
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [PIX_W*PIXELS-1:0]     frame_flat,
    input  logic                        frame_valid,
    input  logic                        flush,
    output logic signed [PIX_W-1:0]     pix_data,
    output logic                        pix_bit,
    output logic                        pix_valid,
    input  logic                        pix_ready,
    output logic                        pix_first,
    output logic                        pix_last,
    output logic                        busy,
    output logic                        frame_done,
    output logic                        frame_dropped
);

    import gan_pkg::*;

    localparam int              IDX_W    = clog2(PIXELS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PIXELS - 1);

    state_t                  r_state;
    state_t                  w_next_state;
    logic [PIX_W*PIXELS-1:0] r_frame;
    logic [IDX_W-1:0]        r_idx;
    logic [IDX_W-1:0]        w_next_idx;
    logic signed [PIX_W-1:0] r_pix_data;
    logic signed [PIX_W-1:0] w_mux_pix;
    logic signed [PIX_W-1:0] w_in_pix0;
    logic                    r_pix_bit;
    logic                    r_pix_valid;
    logic                    r_pix_first;
    logic                    r_pix_last;
    logic                    r_done;
    logic                    r_dropped;
    logic                    w_busy;
    logic                    w_xfer;
    logic                    w_last_xfer;
    logic                    w_accept;
    logic                    w_drop;

    function automatic logic f_thresh(input logic signed [PIX_W-1:0] p);
        return (p >= THRESH);
    endfunction

    // flush outranks a handshake, so a flushed pixel never counts as sent.
    assign w_xfer      = r_pix_valid && pix_ready && !flush;
    assign w_last_xfer = w_xfer && (r_idx == LAST_IDX);
    assign w_next_idx  = r_idx + 1'b1;
    assign w_in_pix0   = frame_flat[PIX_W-1:0];

    frame_pixel_mux #(
        .PIXELS (PIXELS),
        .PIX_W  (PIX_W),
        .IDX_W  (IDX_W)
    ) u_mux (
        .i_flat (r_frame),
        .i_idx  (w_next_idx),
        .o_pix  (w_mux_pix)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) w_next_state = ST_STREAM;
            end
            ST_STREAM: begin
                if (flush)                        w_next_state = ST_IDLE;
                else if (w_last_xfer && !w_accept) w_next_state = ST_IDLE;
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    // A new frame is taken when idle or back-to-back on the final transfer.
    always_comb begin
        w_busy   = 1'b0;
        w_accept = 1'b0;
        w_drop   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_accept = frame_valid && !flush;
            end
            ST_STREAM: begin
                w_busy   = 1'b1;
                w_accept = frame_valid && !flush && w_last_xfer;
                w_drop   = frame_valid && !flush && !w_last_xfer;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_frame     <= '0;
            r_idx       <= '0;
            r_pix_data  <= '0;
            r_pix_bit   <= 1'b0;
            r_pix_valid <= 1'b0;
            r_pix_first <= 1'b0;
            r_pix_last  <= 1'b0;
            r_done      <= 1'b0;
            r_dropped   <= 1'b0;
        end else begin
            r_done    <= w_last_xfer;
            r_dropped <= w_drop;
            if (w_busy && flush) begin
                r_idx       <= '0;
                r_pix_valid <= 1'b0;
                r_pix_first <= 1'b0;
                r_pix_last  <= 1'b0;
            end else if (w_accept) begin
                r_frame     <= frame_flat;
                r_idx       <= '0;
                r_pix_data  <= w_in_pix0;
                r_pix_bit   <= f_thresh(w_in_pix0);
                r_pix_valid <= 1'b1;
                r_pix_first <= 1'b1;
                r_pix_last  <= (LAST_IDX == '0);
            end else if (w_last_xfer) begin
                r_idx       <= '0;
                r_pix_valid <= 1'b0;
                r_pix_first <= 1'b0;
                r_pix_last  <= 1'b0;
            end else if (w_xfer) begin
                r_idx       <= w_next_idx;
                r_pix_data  <= w_mux_pix;
                r_pix_bit   <= f_thresh(w_mux_pix);
                r_pix_first <= 1'b0;
                r_pix_last  <= (w_next_idx == LAST_IDX);
            end
        end
    end

    assign pix_data      = r_pix_data;
    assign pix_bit       = r_pix_bit;
    assign pix_valid     = r_pix_valid;
    assign pix_first     = r_pix_first;
    assign pix_last      = r_pix_last;
    assign busy          = w_busy;
    assign frame_done    = r_done;
    assign frame_dropped = r_dropped;

endmodule

// File: tb/tb_gan_frame_serializer.sv
// Directed bench for gan_frame_serializer with a queue-based pixel scoreboard.
module tb_gan_frame_serializer;

    localparam int PIXELS = 784;
    localparam int PIX_W  = 16;

    typedef struct {
        logic [15:0] d;
        logic        b;
        logic        f;
        logic        l;
    } exp_t;

    logic                    clk;
    logic                    rst_n;
    logic [PIX_W*PIXELS-1:0] frame_flat;
    logic                    frame_valid;
    logic                    flush;
    logic [PIX_W-1:0]        pix_data;
    logic                    pix_bit;
    logic                    pix_valid;
    logic                    pix_ready;
    logic                    pix_first;
    logic                    pix_last;
    logic                    busy;
    logic                    frame_done;
    logic                    frame_dropped;

    int   n_vec = 0;
    int   n_mis = 0;
    exp_t q[$];

    logic        mon_en = 1'b0;
    logic        m_busy = 1'b0;
    logic        exp_done = 1'b0;
    logic        exp_drop = 1'b0;
    logic        prev_stall = 1'b0;
    logic [15:0] prev_d;
    logic        prev_b, prev_f, prev_l;
    logic        mon_x, mon_last, mon_acc;
    exp_t        mon_e;

    gan_frame_serializer #(
        .PIXELS (PIXELS),
        .PIX_W  (PIX_W),
        .THRESH (16'sd0)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .frame_flat    (frame_flat),
        .frame_valid   (frame_valid),
        .flush         (flush),
        .pix_data      (pix_data),
        .pix_bit       (pix_bit),
        .pix_valid     (pix_valid),
        .pix_ready     (pix_ready),
        .pix_first     (pix_first),
        .pix_last      (pix_last),
        .busy          (busy),
        .frame_done    (frame_done),
        .frame_dropped (frame_dropped)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_vec++;
        assert (obs === expv) else begin
            n_mis++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // kind 0: ramp i; kind 1: -3*(i+1); kind 2: -256/0/+256 repeating
    function automatic int pix_val(input int kind, input int i);
        case (kind)
            0:       return i;
            1:       return -3 * (i + 1);
            default: return (i % 3 == 0) ? -256 : ((i % 3 == 1) ? 0 : 256);
        endcase
    endfunction

    function automatic logic pix_bit_exp(input int kind, input int i);
        case (kind)
            0:       return 1'b1;
            1:       return 1'b0;
            default: return (i % 3 != 0);
        endcase
    endfunction

    task automatic build_frame(input int kind, input bit push);
        int          v;
        logic [15:0] w;
        exp_t        e;
        for (int i = PIXELS - 1; i >= 0; i--) begin
            v = pix_val(kind, i);
            w = v[15:0];
            frame_flat = {frame_flat[PIX_W*PIXELS-PIX_W-1:0], w};
        end
        if (push) begin
            for (int i = 0; i < PIXELS; i++) begin
                v   = pix_val(kind, i);
                e.d = v[15:0];
                e.b = pix_bit_exp(kind, i);
                e.f = (i == 0);
                e.l = (i == PIXELS - 1);
                q.push_back(e);
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic model_clear();
        q.delete();
        m_busy     = 1'b0;
        exp_done   = 1'b0;
        exp_drop   = 1'b0;
        prev_stall = 1'b0;
    endtask

    task automatic send(input int kind);
        build_frame(kind, 1'b1);
        frame_valid = 1'b1;
        step();
        frame_valid = 1'b0;
        build_frame(1 - (kind % 2), 1'b0);
    endtask

    task automatic drain(input string tag, input int budget, input bit rnd);
        int k;
        k = 0;
        while ((q.size() != 0 || m_busy) && k < budget) begin
            if (rnd) pix_ready = 1'($urandom_range(0, 1));
            step();
            k++;
        end
        pix_ready = 1'b1;
        chk(tag, q.size(), 0);
        step();
        step();
        chk({tag, "_busy"}, busy, 0);
    endtask

    task automatic wait_q(input string tag, input int size, input int budget);
        int k;
        k = 0;
        while (q.size() != size && k < budget) begin
            step();
            k++;
        end
        chk(tag, q.size(), size);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_data"},  pix_data, 0);
        chk({tag, "_bit"},   pix_bit, 0);
        chk({tag, "_valid"}, pix_valid, 0);
        chk({tag, "_first"}, pix_first, 0);
        chk({tag, "_last"},  pix_last, 0);
        chk({tag, "_busy"},  busy, 0);
        chk({tag, "_done"},  frame_done, 0);
        chk({tag, "_drop"},  frame_dropped, 0);
    endtask

    // Scoreboard/monitor: inputs are stable at the falling edge, so the
    // handshake about to happen on the next rising edge is decided here.
    always @(negedge clk) begin
        if (mon_en && rst_n) begin
            mon_x    = pix_valid && pix_ready && !flush;
            mon_last = 1'b0;
            chk("busy", busy, m_busy);
            chk("pix_valid", pix_valid, m_busy);
            chk("frame_done", frame_done, exp_done);
            chk("frame_dropped", frame_dropped, exp_drop);
            if (prev_stall) begin
                chk("stall_data", pix_data, prev_d);
                chk("stall_bit", pix_bit, prev_b);
                chk("stall_first", pix_first, prev_f);
                chk("stall_last", pix_last, prev_l);
            end
            if (mon_x) begin
                chk("xfer_expected", q.size() > 0, 1);
                if (q.size() > 0) begin
                    mon_e = q.pop_front();
                    chk("pix_data", pix_data, mon_e.d);
                    chk("pix_bit", pix_bit, mon_e.b);
                    chk("pix_first", pix_first, mon_e.f);
                    chk("pix_last", pix_last, mon_e.l);
                    mon_last = mon_e.l;
                end
            end
            exp_done = mon_x && mon_last;
            exp_drop = frame_valid && !flush && m_busy && !(mon_x && mon_last);
            mon_acc  = frame_valid && !flush && (!m_busy || (mon_x && mon_last));
            if (m_busy && flush)       m_busy = 1'b0;
            else if (mon_acc)          m_busy = 1'b1;
            else if (mon_x && mon_last) m_busy = 1'b0;
            prev_stall = pix_valid && !pix_ready && !flush;
            prev_d = pix_data;
            prev_b = pix_bit;
            prev_f = pix_first;
            prev_l = pix_last;
        end
    end

    initial begin
        rst_n       = 1'b0;
        frame_flat  = '0;
        frame_valid = 1'b0;
        flush       = 1'b0;
        pix_ready   = 1'b1;
        repeat (3) step();
        chk_all_zero("reset");
        rst_n  = 1'b1;
        mon_en = 1'b1;
        step();

        // Ramp frame, ready held high
        send(0);
        chk("ramp_first_latency", pix_valid, 1);
        chk("ramp_first_flag", pix_first, 1);
        drain("ramp_drain", 2000, 1'b0);

        // Same ramp under random backpressure
        send(0);
        drain("bp_drain", 6000, 1'b1);

        // Threshold pattern
        send(2);
        drain("thresh_drain", 2000, 1'b0);

        // Second frame_valid mid-stream is dropped
        send(0);
        wait_q("drop_wait", PIXELS - 100, 400);
        build_frame(1, 1'b0);
        frame_valid = 1'b1;
        step();
        frame_valid = 1'b0;
        chk("drop_pulse", frame_dropped, 1);
        step();
        chk("drop_once", frame_dropped, 0);
        drain("drop_drain", 2000, 1'b0);

        // New frame coincident with last transfer of the previous one
        send(0);
        wait_q("coinc_wait", 1, 2000);
        build_frame(1, 1'b1);
        frame_valid = 1'b1;
        step();
        frame_valid = 1'b0;
        build_frame(2, 1'b0);
        chk("coinc_valid", pix_valid, 1);
        chk("coinc_first", pix_first, 1);
        chk("coinc_data", pix_data, 16'hfffd);
        chk("coinc_done", frame_done, 1);
        drain("coinc_drain", 2000, 1'b0);

        // Flush at index 300 while stalled
        send(0);
        wait_q("flush_wait", PIXELS - 300, 1000);
        chk("flush_idx300", pix_data, 300);
        pix_ready = 1'b0;
        repeat (3) step();
        flush     = 1'b1;
        pix_ready = 1'b1;
        q.delete();
        step();
        flush = 1'b0;
        chk("flush_valid", pix_valid, 0);
        chk("flush_busy", busy, 0);
        step();
        chk("flush_no_done", frame_done, 0);
        send(0);
        drain("post_flush_drain", 2000, 1'b0);

        // flush in IDLE masks frame_valid without a drop pulse
        build_frame(0, 1'b0);
        flush       = 1'b1;
        frame_valid = 1'b1;
        step();
        flush       = 1'b0;
        frame_valid = 1'b0;
        chk("idle_flush_busy", busy, 0);
        chk("idle_flush_drop", frame_dropped, 0);
        step();

        // Asynchronous reset mid-frame
        send(1);
        wait_q("rst_wait", PIXELS - 50, 400);
        @(posedge clk);
        #3;
        mon_en = 1'b0;
        rst_n  = 1'b0;
        #1;
        chk_all_zero("mid_reset");
        model_clear();
        repeat (2) step();
        rst_n  = 1'b1;
        mon_en = 1'b1;
        repeat (5) step();
        chk("post_reset_valid", pix_valid, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
